// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter sharing one DRAM port among NUM_REQ requesters.
// Ports: clk/rst (async active-low); req_valid/req_addr/req_write/req_wdata in,
//   req_ready/req_rdata/req_error out (one-cycle pulses); dram_req/dram_addr/
//   dram_write/dram_wdata out, dram_ready/dram_rdata in; busy, grant_id status.
// Optional: define DRAM_ARB_TIMEOUT_EN to enable the GRANT watchdog (TIMEOUT_CYCLES).
module dram_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 11,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_error,
  output logic                        dram_req,
  output logic [ADDR_W-1:0]           dram_addr,
  output logic                        dram_write,
  output logic [DATA_W-1:0]           dram_wdata,
  input  logic                        dram_ready,
  input  logic [DATA_W-1:0]           dram_rdata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_e;
  state_e              state_q;
  logic [IW-1:0]       ptr_q, grant_q, win_d, ptr_d;
  logic                dram_req_q, dram_write_q, busy_q, timeout;
  logic [ADDR_W-1:0]   dram_addr_q;
  logic [DATA_W-1:0]   dram_wdata_q, rdata_q;
  logic [NUM_REQ-1:0]  ready_q, error_q, onehot;

  // Scan from the pointer downward-last so the closest set bit at or above ptr wins.
  always_comb begin
    win_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) win_d = IW'((int'(ptr_q) + k) % NUM_REQ);
  end

  assign ptr_d  = (win_d == IW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
  assign onehot = NUM_REQ'(1) << grant_q;

`ifdef DRAM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q;
  // Held at zero outside GRANT, so it starts from zero on every GRANT entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= (state_q == GRANT) ? cnt_q + 1'b1 : '0;
  end
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] tout_unused;
  assign tout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      dram_req_q   <= 1'b0;
      dram_write_q <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
      error_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      ready_q <= '0;
      error_q <= '0;
      case (state_q)
        IDLE: if (|req_valid) begin
          state_q      <= GRANT;
          grant_q      <= win_d;
          ptr_q        <= ptr_d;
          dram_addr_q  <= req_addr[win_d*ADDR_W +: ADDR_W];
          dram_write_q <= req_write[win_d];
          dram_wdata_q <= req_wdata[win_d*DATA_W +: DATA_W];
          dram_req_q   <= 1'b1;
          busy_q       <= 1'b1;
        end
        // A dram_ready arriving in the expiry cycle still counts as a normal completion.
        GRANT: if (dram_ready || timeout) begin
          state_q    <= DONE;
          dram_req_q <= 1'b0;
          ready_q    <= dram_ready ? onehot : '0;
          error_q    <= dram_ready ? '0 : onehot;
          rdata_q    <= (dram_ready && !dram_write_q) ? dram_rdata : '0;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign req_error  = error_q;
  assign req_rdata  = rdata_q;
  assign dram_req   = dram_req_q;
  assign dram_addr  = dram_addr_q;
  assign dram_write = dram_write_q;
  assign dram_wdata = dram_wdata_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized checks of dram_arbiter against a transaction-level model.
module tb_dram_arbiter;
  localparam int N = 2, AW = 32, DW = 11;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]    req_valid = '0, req_write = '0, req_ready, req_error;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   req_rdata, dram_wdata, dram_rdata = '0;
  logic            dram_req, dram_write, busy, dram_ready = 1'b0;
  logic [AW-1:0]   dram_addr;
  logic [0:0]      grant_id;
  int errs = 0, checks = 0, mptr = 0;

  dram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata), .req_error(req_error),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_write(dram_write), .dram_wdata(dram_wdata),
    .dram_ready(dram_ready), .dram_rdata(dram_rdata), .busy(busy), .grant_id(grant_id));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: first requesting index at or after the pointer, wrapping.
  function automatic int rr(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_write[i] = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, dram_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gid"}, grant_id, 0);
    chk({tag, "_addr"}, dram_addr, 0);
    chk({tag, "_wr"}, dram_write, 0);
    chk({tag, "_wdata"}, dram_wdata, 0);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rdata"}, req_rdata, 0);
    chk({tag, "_err"}, req_error, 0);
  endtask

  // One full transaction starting in IDLE with at least one req_valid set.
  task automatic txn(input int lat, input logic [DW-1:0] rd, input bit hold);
    int w;
    logic [AW-1:0] ea;
    logic ew;
    logic [DW-1:0] ed;
    w  = rr(req_valid, mptr);
    ea = req_addr[w*AW +: AW];
    ew = req_write[w];
    ed = req_wdata[w*DW +: DW];
    step();
    chk("grant_busy", busy, 1);
    chk("grant_req", dram_req, 1);
    chk("grant_id", grant_id, 64'(w));
    chk("grant_addr", dram_addr, ea);
    chk("grant_write", dram_write, ew);
    chk("grant_wdata", dram_wdata, ed);
    chk("grant_noready", req_ready, 0);
    repeat (lat) begin
      step();
      chk("wait_req", dram_req, 1);
      chk("wait_addr", dram_addr, ea);
    end
    dram_ready = 1'b1;
    dram_rdata = rd;
    step();
    dram_ready = 1'b0;
    dram_rdata = DW'($urandom);
    chk("done_ready", req_ready, 64'(1) << w);
    chk("done_rdata", req_rdata, ew ? 64'(0) : 64'(rd));
    chk("done_req", dram_req, 0);
    chk("done_busy", busy, 1);
    chk("done_err", req_error, 0);
    chk("done_gid", grant_id, 64'(w));
    if (!hold) req_valid[w] = 1'b0;
    mptr = (w + 1) % N;
    step();
    chk("post_busy", busy, 0);
    chk("post_ready", req_ready, 0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    // Single read
    set_req(0, 32'h0000_0128, 1'b0, 11'h000);
    txn(3, 11'h5A3, 1'b0);
    // Write from requester 1
    set_req(1, 32'h0000_0A40, 1'b1, 11'h07F);
    txn(1, 11'h3C3, 1'b0);
    // Round robin from reset with both valids held
    rst = 1'b0;
    #1 chk_all_zero("rst2");
    mptr = 0;
    step();
    rst = 1'b1;
    set_req(0, 32'h1000, 1'b0, 11'h011);
    set_req(1, 32'h2000, 1'b0, 11'h022);
    for (int t = 0; t < 4; t++) txn(t, DW'(11'h100 + t), 1'b1);
    // Reset mid-GRANT; pointer must return to 0
    step();
    chk("mid_req", dram_req, 1);
    chk("mid_gid", grant_id, 0);
    rst = 1'b0;
    #1 chk_all_zero("mid_rst");
    mptr = 0;
    step();
    rst = 1'b1;
    txn(0, 11'h6B1, 1'b0);
    // Spurious ready while idle
    req_valid = '0;
    dram_ready = 1'b1;
    repeat (3) begin
      step();
      chk("spur_busy", busy, 0);
      chk("spur_req", dram_req, 0);
      chk("spur_ready", req_ready, 0);
    end
    dram_ready = 1'b0;
    set_req(0, 32'h3000, 1'b0, 11'h033);
    set_req(1, 32'h4000, 1'b0, 11'h044);
    txn(2, 11'h2E7, 1'b0);
    txn(0, 11'h1D2, 1'b0);
    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom, 1'($urandom), DW'($urandom));
      if (req_valid == '0) set_req($urandom_range(0, N - 1), $urandom, 1'($urandom), DW'($urandom));
      txn($urandom_range(0, 4), DW'($urandom), 1'b0);
    end
`ifdef DRAM_ARB_TIMEOUT_EN
    req_valid = '0;
    set_req(0, 32'h5000, 1'b0, 11'h055);
    mptr = 0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("to_req", dram_req, 1);
    repeat (15) begin
      step();
      chk("to_wait_req", dram_req, 1);
      chk("to_wait_err", req_error, 0);
    end
    step();
    chk("to_err", req_error, 1);
    chk("to_ready", req_ready, 0);
    chk("to_dreq", dram_req, 0);
    chk("to_rdata", req_rdata, 0);
    req_valid = '0;
    step();
    chk("to_post_err", req_error, 0);
    chk("to_post_busy", busy, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter that shares the single DRAM port between NUM_REQ cache controllers (data cache, instruction cache, and future requesters). Each requester raises a miss-fill or write-through request; the arbiter grants one at a time, drives the DRAM request/ready handshake, and returns read data plus a one-cycle completion pulse to the granted requester. Sits between the cache controllers' mem_req/mem_ready side and the DRAM model.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 11, data word width, matches cache data field
- TIMEOUT_CYCLES, 255, watchdog limit; used only with DRAM_ARB_TIMEOUT_EN
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester request, held until its req_ready pulse
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_write  in  NUM_REQ  1 = write (SW), 0 = read (LW fill)
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-cycle completion pulse, one-hot
- req_rdata  out  DATA_W  read data, valid in the req_ready cycle
- req_error  out  NUM_REQ  one-cycle timeout pulse, one-hot
- dram_req  out  1  DRAM request, held until dram_ready
- dram_addr, dram_write, dram_wdata  out  ADDR_W / 1 / DATA_W  latched request fields
- dram_ready  in  1  DRAM completion
- dram_rdata  in  DATA_W  DRAM read data, valid with dram_ready
- busy  out  1  high in GRANT and DONE
- grant_id  out  $clog2(NUM_REQ)  index of granted requester, stable in GRANT/DONE

## Operation
- States: IDLE, GRANT, DONE. Reset enters IDLE; priority pointer = 0.
- IDLE: if any req_valid, pick first set bit searching from pointer upward with wrap; latch its addr/write/wdata into dram_* registers, grant_id = winner, pointer <= winner+1 mod NUM_REQ, go GRANT. No valid: stay.
- GRANT: dram_req = 1, dram_* stable. On dram_ready = 1: req_rdata <= dram_rdata (read) or 0 (write), go DONE.
- DONE: req_ready[grant_id] = 1 for exactly this cycle; dram_req = 0; next IDLE. No arbitration in DONE, so a requester still holding req_valid is not re-granted.
- Requester deasserting req_valid during GRANT does not abort; transaction completes and pulse is still issued.
- dram_ready outside GRANT is ignored.
- Reset (any state): all outputs 0, registers cleared, pointer 0, state IDLE, asynchronously.

## Timing
- Reset values: dram_req, dram_addr, dram_write, dram_wdata, req_ready, req_rdata, req_error, busy, grant_id all 0.
- req_valid sampled in IDLE at edge t -> dram_req and busy high from t+1.
- dram_ready sampled at edge u -> req_ready and req_rdata valid in cycle u+1 (DONE); IDLE at u+2; earliest next dram_req at u+3.
- Minimum transaction: 3 cycles when DRAM responds in the first GRANT cycle.
- Exactly one req_ready or req_error bit high per transaction; never both.
- Simultaneous valids: winner strictly by round-robin pointer; starvation bound NUM_REQ-1 transactions.

## Configuration
- DRAM_ARB_TIMEOUT_EN defined: 8-bit-or-wider counter clears on GRANT entry, increments each GRANT cycle without dram_ready; reaching TIMEOUT_CYCLES forces DONE with req_error[grant_id] pulse instead of req_ready, req_rdata = 0, dram_req dropped. dram_ready in the same cycle as expiry wins (normal completion).
- Not defined: no counter, GRANT waits indefinitely, req_error tied to 0.

## Test plan
- Single read: req_valid[0]=1, addr 0x0000_0128, dram_ready after 4 cycles with dram_rdata 11'h5A3 -> dram_addr=0x128, dram_write=0, req_ready[0] pulse one cycle with req_rdata 11'h5A3.
- Round robin: both valids held continuously for 4 transactions from reset -> grant order 0,1,0,1; req_ready pulses alternate.
- Write: req_valid[1]=1, req_write=1, wdata 11'h07F -> dram_write=1, dram_wdata 11'h07F, req_ready[1] pulse, req_rdata 0.
- Reset mid-GRANT: rst low while dram_req=1 -> all outputs 0 immediately; after release, requester 0 granted first.
- Timeout (macro defined, TIMEOUT_CYCLES=16): dram_ready never asserted -> req_error[0] pulse after 16 GRANT cycles, req_ready stays 0, dram_req low.
- Spurious ready: dram_ready=1 while IDLE -> no state change, no pulses.
